fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_reader.sv | 106 ++++++++++
 tb/tb_fifo_stream_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a non-FWFT FIFO into a valid/ready stream.
// Reads are issued against a credit of free buffer slots, tracked across the
// FIFO's fixed read latency, and landed in a small circular buffer. OUT_LAST
// marks every PKT_LEN-th accepted word.
module fifo_stream_reader #(
  parameter int DWIDTH     = 32,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4,
  parameter int PKT_LEN    = 1024
) (
  input  logic              RCLOCK,
  input  logic              RRESET_N,
  input  logic              ENABLE,
  input  logic              EMPTY,
  input  logic [DWIDTH-1:0] Q,
  output logic              RE,
  output logic [DWIDTH-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic              PKT_DONE
);

  localparam int PW = $clog2(BUF_DEPTH);
  // Wide enough to hold buf_cnt + inflight without wrapping.
  localparam int CW = $clog2(BUF_DEPTH + RD_LATENCY + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [15:0]   LAST_IDX = 16'(PKT_LEN - 1);

  logic [RD_LATENCY-1:0]            inflight;
  logic [CW-1:0]                    inflight_cnt;
  logic [CW-1:0]                    buf_cnt;
  logic [CW-1:0]                    credit;
  logic [BUF_DEPTH-1:0][DWIDTH-1:0] buf_mem;
  logic [PW-1:0]                    wr_ptr;
  logic [PW-1:0]                    rd_ptr;
  logic [15:0]                      wcnt;
  logic                             capture;
  logic                             accept;

  // Outstanding reads = popcount of the in-flight shift register.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight_cnt = inflight_cnt + CW'(inflight[i]);
  end

  // A read is only issued when a slot is reserved for its landing word.
  assign credit    = buf_cnt + inflight_cnt;
  assign RE        = ENABLE & ~EMPTY & (credit < DEPTH_C) & RRESET_N;
  assign capture   = inflight[RD_LATENCY-1];
  assign OUT_VALID = (buf_cnt != '0);
  assign OUT_DATA  = buf_mem[rd_ptr];
  assign OUT_LAST  = OUT_VALID & (wcnt == LAST_IDX);
  assign accept    = OUT_VALID & OUT_READY;

  // In-flight tracker: issued read bit walks RD_LATENCY stages to capture.
  always_ff @(posedge RCLOCK or negedge RRESET_N) begin
    if (!RRESET_N) begin
      inflight <= '0;
    end else begin
      inflight[0] <= RE;
      for (int i = 1; i < RD_LATENCY; i++)
        inflight[i] <= inflight[i-1];
    end
  end

  // Circular buffer: capture from Q at wr_ptr, present rd_ptr, count occupancy.
  always_ff @(posedge RCLOCK or negedge RRESET_N) begin
    if (!RRESET_N) begin
      buf_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_cnt <= '0;
    end else begin
      if (capture) begin
        buf_mem[wr_ptr] <= Q;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (accept)
        rd_ptr <= rd_ptr + PW'(1);
      case ({capture, accept})
        2'b10:   buf_cnt <= buf_cnt + CW'(1);
        2'b01:   buf_cnt <= buf_cnt - CW'(1);
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Packet framing: word counter wraps at PKT_LEN, done pulses after last accept.
  always_ff @(posedge RCLOCK or negedge RRESET_N) begin
    if (!RRESET_N) begin
      wcnt     <= '0;
      PKT_DONE <= 1'b0;
    end else begin
      if (accept)
        wcnt <= (wcnt == LAST_IDX) ? 16'd0 : wcnt + 16'd1;
      PKT_DONE <= accept & OUT_LAST;
    end
  end

  // A landing word must always find a free slot.
  a_no_overrun: assert property (@(posedge RCLOCK) disable iff (!RRESET_N)
    capture |-> (buf_cnt < DEPTH_C));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model with fixed read latency, an
// expected-word queue, and a per-cycle checker of the stream outputs.
module tb_fifo_stream_reader;

  localparam int DW  = 32;
  localparam int L   = 3;
  localparam int BD  = 8;
  localparam int PKT = 4;

  logic          RCLOCK = 1'b0;
  logic          RRESET_N = 1'b0;
  logic          ENABLE = 1'b0;
  logic          EMPTY = 1'b1;
  logic [DW-1:0] Q;
  logic          RE;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic          OUT_LAST;
  logic          PKT_DONE;

  fifo_stream_reader #(.DWIDTH(DW), .RD_LATENCY(L), .BUF_DEPTH(BD), .PKT_LEN(PKT)) dut (
    .RCLOCK(RCLOCK), .RRESET_N(RRESET_N), .ENABLE(ENABLE), .EMPTY(EMPTY), .Q(Q),
    .RE(RE), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_LAST(OUT_LAST), .PKT_DONE(PKT_DONE)
  );

  always #5 RCLOCK = ~RCLOCK;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [DW-1:0] in_q[$];     // words written by stimulus, visible after next edge
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];    // words read from FIFO and not yet accepted
  int            stamp_q[$];  // edge number at which each word was read
  logic [DW-1:0] qpipe [L];
  int            edge_cnt = 0;

  assign Q = qpipe[L-1];

  // FIFO read side: RE sampled at edge E0 puts the word on Q at edge E0+L.
  always @(posedge RCLOCK) begin
    logic [DW-1:0] w;
    edge_cnt++;
    for (int i = 1; i < L; i++) qpipe[i] <= qpipe[i-1];
    if (RE) begin
      w = fifo_q.pop_front();
      exp_q.push_back(w);
      stamp_q.push_back(edge_cnt);
      qpipe[0] <= w;
    end
    while (in_q.size() > 0) fifo_q.push_back(in_q.pop_front());
    EMPTY <= (fifo_q.size() == 0);
  end

  // ---------------- per-cycle checker ----------------
  int mcnt = 0;          // accepted words modulo PKT
  bit done_nxt = 0;
  int re_cnt = 0, acc_cnt = 0, last_cnt = 0, done_cnt = 0;

  always @(negedge RCLOCK) begin
    bit ev, el, acc;
    #1;
    if (!RRESET_N) begin
      exp_q.delete();
      stamp_q.delete();
      mcnt = 0;
      done_nxt = 0;
      chk("reset_outputs", {RE, OUT_VALID, OUT_LAST, PKT_DONE, OUT_DATA}, '0);
    end else begin
      ev = (exp_q.size() > 0) && (edge_cnt >= stamp_q[0] + L);
      el = ev && (mcnt == PKT - 1);
      chk("OUT_VALID", OUT_VALID, ev);
      chk("RE", RE, ENABLE && !EMPTY && (exp_q.size() < BD));
      chk("OUT_LAST", OUT_LAST, el);
      chk("PKT_DONE", PKT_DONE, done_nxt);
      if (ev) chk("OUT_DATA", OUT_DATA, exp_q[0]);
      if (RE) re_cnt++;
      if (PKT_DONE) done_cnt++;
      acc = ev && OUT_READY;
      done_nxt = acc && el;
      if (acc) begin
        void'(exp_q.pop_front());
        void'(stamp_q.pop_front());
        mcnt = (mcnt + 1) % PKT;
        acc_cnt++;
        if (el) last_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_drain(input int budget, input bit rnd_ready);
    int n = 0;
    while (in_q.size() > 0 || fifo_q.size() > 0 || exp_q.size() > 0) begin
      @(negedge RCLOCK);
      OUT_READY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
      if (n > budget) begin
        chk("drain_timeout", 1, 0);
        break;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, fv, nre, nvld, run, rmax, b_re, b_acc, b_last, b_done, pushed, cyc;
    // Reset state
    repeat (3) @(negedge RCLOCK);
    #2;
    chk("rst_RE", RE, 0);
    chk("rst_OUT_VALID", OUT_VALID, 0);
    chk("rst_OUT_LAST", OUT_LAST, 0);
    chk("rst_OUT_DATA", OUT_DATA, 0);
    chk("rst_PKT_DONE", PKT_DONE, 0);
    @(negedge RCLOCK);
    RRESET_N = 1'b1;

    // T1: 8 words, ready high, latency and throughput
    OUT_READY = 1'b1;
    ENABLE = 1'b1;
    @(negedge RCLOCK);
    for (int i = 1; i <= 8; i++) in_q.push_back(DW'(i));
    fr = -1; fv = -1; nre = 0; nvld = 0; run = 0; rmax = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge RCLOCK);
      #2;
      if (RE) begin nre++; if (fr < 0) fr = k; end
      if (OUT_VALID) begin
        nvld++; run++; if (run > rmax) rmax = run;
        if (fv < 0) begin fv = k; chk("t1_first_data", OUT_DATA, 1); end
      end else run = 0;
    end
    chk("t1_first_word_latency", fv - fr, L + 1);
    chk("t1_re_cycles", nre, 8);
    chk("t1_valid_cycles", nvld, 8);
    chk("t1_consecutive_valid", rmax, 8);

    // T2: 10 words with PKT_LEN=4
    b_last = last_cnt; b_done = done_cnt;
    @(negedge RCLOCK);
    for (int i = 0; i < 10; i++) in_q.push_back(32'h0000_0020 + DW'(i));
    wait_drain(200, 0);
    repeat (3) @(negedge RCLOCK);
    chk("t2_last_count", last_cnt - b_last, 2);
    chk("t2_done_pulses", done_cnt - b_done, 2);
    chk("t2_model_wcnt", mcnt, 2);

    // T3: backpressure with 20 words queued
    OUT_READY = 1'b0;
    b_re = re_cnt; b_acc = acc_cnt;
    @(negedge RCLOCK);
    for (int i = 0; i < 20; i++) in_q.push_back(32'h0000_0100 + DW'(i));
    repeat (30) @(negedge RCLOCK);
    #2;
    chk("t3_re_cycles_stalled", re_cnt - b_re, BD);
    chk("t3_held_valid", OUT_VALID, 1);
    chk("t3_held_data", OUT_DATA, 32'h0000_0100);
    wait_drain(400, 0);
    chk("t3_drained_words", acc_cnt - b_acc, 20);

    // T4: 1000 random words, random ready
    b_acc = acc_cnt; pushed = 0; cyc = 0;
    while ((pushed < 1000 || in_q.size() > 0 || fifo_q.size() > 0 || exp_q.size() > 0)
           && cyc < 20000) begin
      @(negedge RCLOCK);
      cyc++;
      OUT_READY = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
        in_q.push_back($urandom);
        pushed++;
      end
    end
    chk("t4_finished_in_budget", cyc < 20000, 1);
    chk("t4_words_out", acc_cnt - b_acc, 1000);

    // T5: drop ENABLE with 2 reads in flight
    OUT_READY = 1'b1;
    ENABLE = 1'b0;
    @(negedge RCLOCK);
    for (int i = 0; i < 5; i++) in_q.push_back(32'h0000_0A00 + DW'(i));
    @(negedge RCLOCK);
    b_re = re_cnt; b_acc = acc_cnt;
    ENABLE = 1'b1;
    repeat (2) @(negedge RCLOCK);
    ENABLE = 1'b0;
    repeat (10) @(negedge RCLOCK);
    chk("t5_re_while_disabled", re_cnt - b_re, 2);
    chk("t5_inflight_delivered", acc_cnt - b_acc, 2);
    ENABLE = 1'b1;
    wait_drain(100, 0);
    chk("t5_all_delivered", acc_cnt - b_acc, 5);

    // T6: reset mid-packet with 3 words buffered
    OUT_READY = 1'b0;
    @(negedge RCLOCK);
    for (int i = 0; i < 3; i++) in_q.push_back(32'h0000_0B00 + DW'(i));
    repeat (8) @(negedge RCLOCK);
    #2;
    chk("t6_buffered_valid", OUT_VALID, 1);
    @(negedge RCLOCK);
    RRESET_N = 1'b0;
    #2;
    chk("t6_rst_RE", RE, 0);
    chk("t6_rst_OUT_VALID", OUT_VALID, 0);
    chk("t6_rst_OUT_LAST", OUT_LAST, 0);
    chk("t6_rst_OUT_DATA", OUT_DATA, 0);
    chk("t6_rst_PKT_DONE", PKT_DONE, 0);
    repeat (2) @(negedge RCLOCK);
    RRESET_N = 1'b1;
    b_last = last_cnt; b_done = done_cnt; b_acc = acc_cnt;
    OUT_READY = 1'b1;
    @(negedge RCLOCK);
    for (int i = 0; i < 4; i++) in_q.push_back(32'h0000_0C00 + DW'(i));
    wait_drain(100, 0);
    repeat (3) @(negedge RCLOCK);
    chk("t6_words_after_reset", acc_cnt - b_acc, 4);
    chk("t6_last_after_reset", last_cnt - b_last, 1);
    chk("t6_done_after_reset", done_cnt - b_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
